melody_sequencer: RTL and testbench
===================================

// Module: melody_sequencer
// PURPOSE
//   Upstream stage of the Speaker tone generator: selects which 4-bit note code drives Speaker.hex.
//   Passes live key presses through, records them as (note, duration) segments into on-chip memory,
//   and plays the stored melody back with tick-accurate timing.
//   note_on gates the audio pin downstream (Speaker output is ANDed with note_on at top level).
// PARAMETERS
//   DEPTH     32         number of stored segments (power of 2, >=2)
//   DUR_W     8          segment duration width in ticks; max duration = 2**DUR_W-1
//   TICK_DIV  1000000    clk cycles per timing tick (10 ms at 100 MHz); sims use 4
// PORTS
//   clk        in   1               system clock, 100 MHz
//   rst_n      in   1               asynchronous active-low reset
//   keys       in   16              debounced piano keys; bit i = note code i
//   rec_p      in   1               one-cycle pulse: start recording
//   play_p     in   1               one-cycle pulse: start playback
//   stop_p     in   1               one-cycle pulse: end record/playback
//   hex        out  4               note code to Speaker
//   note_on    out  1               1 = sound hex, 0 = silence
//   recording  out  1               state == REC
//   playing    out  1               state == PLAY
//   full       out  1               memory holds DEPTH segments
//   length     out  $clog2(DEPTH+1) number of stored segments
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE, hex=0, note_on=0, length=0, full=0, prescaler/duration/index=0.
//   Key encode (combinational): code = index of lowest set bit of keys; rest = (keys==0).
//   Tick: prescaler counts 0..TICK_DIV-1, tick=1 on terminal count; prescaler clears on every
//     state entry and every segment start (record or playback), so segment timing is exact.
//   Pulse priority when simultaneous: stop_p > rec_p > play_p. Pulses not legal in current state are ignored.
//   IDLE: hex/note_on registered from live keys (1-cycle latency; hex holds last code on rest).
//     rec_p -> REC: length:=0, full:=0, segment inactive.
//     play_p with length>0 -> PLAY at index 0; play_p with length==0 ignored.
//   REC: live passthrough as in IDLE. Segment = {rest, code, dur}.
//     Before first key press: nothing recorded (leading rest dropped).
//     First press opens a segment, dur=0. dur increments on each tick.
//     On (rest,code) change: if dur>0 write segment to mem[length], length++; then open new segment.
//       dur==0 segments (shorter than one tick) are discarded, not written.
//     dur reaching 2**DUR_W-1: write segment, open new segment with same (rest,code), dur=0.
//     Write with length==DEPTH-1 -> length=DEPTH, full=1, state -> IDLE same cycle.
//     stop_p: flush open segment if dur>0 (same rule), then -> IDLE. Trailing rest is flushed as recorded.
//   PLAY: load mem[index]; hex=code, note_on=~rest, from cycle after load; remaining=dur.
//     remaining decrements on tick; at 0, index++ and next entry loads; no gap cycle between segments.
//     After index length-1 expires -> IDLE, note_on=0. stop_p -> IDLE next cycle, note_on=0.
//     rec_p ignored in PLAY; play_p ignored in PLAY and REC.
//   full clears only on rec_p. length persists across plays; reset clears it.
//   Memory: DEPTH x (1+4+DUR_W) synchronous-read register/BRAM array; contents not reset (length guards reads).
//   Reset mid-record or mid-play: immediate return to reset values; recorded data discarded (length=0).
// TESTING  (TICK_DIV=4, DEPTH=4, DUR_W=3)
//   Live: IDLE, keys=16'h0008 -> hex=3, note_on=1 one cycle later; keys=0 -> note_on=0, hex stays 3.
//   Record/play: rec_p; key 2 for 3 ticks; rest 2 ticks; key 5 for 1 tick; stop_p -> length=3;
//     play_p -> hex=2 on 12 clk, silence 8 clk, hex=5 on 4 clk, then playing=0, note_on=0.
//   Saturate+full: rec_p; hold key 1 for 30 ticks -> segments of 7 ticks written; 4th write sets
//     full=1, length=4, recording=0 at that edge.
//   Glitch: in REC, key 4 pressed for 2 clk (<1 tick) between key 0 segments -> dropped, length unaffected by it.
//   Priority: stop_p and play_p same cycle in IDLE -> stays IDLE; rec_p+play_p -> REC; play_p with length=0 ignored.
//   Async reset: assert rst_n=0 mid-PLAY between edges -> outputs zero immediately, length=0, state IDLE.

Source files
------------

// File: rtl/melody_sequencer.sv
// Melody sequencer: passes live key presses to the Speaker note code, records them as
// (rest, note, duration) segments and plays the stored melody back with tick-accurate timing.
module melody_sequencer #(
   parameter int DEPTH    = 32,
   parameter int DUR_W    = 8,
   parameter int TICK_DIV = 1000000,
   localparam int LW      = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [15:0]   keys,
   input  logic          rec_p,
   input  logic          play_p,
   input  logic          stop_p,
   output logic [3:0]    hex,
   output logic          note_on,
   output logic          recording,
   output logic          playing,
   output logic          full,
   output logic [LW-1:0] length
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = 1 + 4 + DUR_W;
   localparam logic [DUR_W-1:0] DUR_MAX = '1;

   typedef enum logic [1:0] {IDLE, REC, PLAY} state_t;

   state_t           state_reg, state_next;
   logic [PW-1:0]    presc_reg, presc_next;
   logic [DUR_W-1:0] dur_reg, dur_next;   // REC: ticks elapsed; PLAY: ticks remaining
   logic [AW-1:0]    idx_reg, idx_next;
   logic             seg_active_reg, seg_active_next;
   logic             seg_rest_reg, seg_rest_next;
   logic [3:0]       seg_code_reg, seg_code_next;
   logic [3:0]       hex_reg, hex_next;
   logic             note_on_reg, note_on_next;
   logic [LW-1:0]    length_reg, length_next;
   logic             full_reg, full_next;
   logic             load_pend_reg, load_pend_next;

   logic [SW-1:0]    mem [DEPTH];
   logic [SW-1:0]    rd_data_reg;
   logic [AW-1:0]    rd_addr;
   logic             wr_en;
   logic [SW-1:0]    wr_data;

   logic [3:0]       key_code;
   logic             key_rest;
   logic             tick;
   logic [DUR_W-1:0] dur_eff;
   logic             seg_changed;
   logic             do_write;
   logic             rd_rest;
   logic [3:0]       rd_code;
   logic [DUR_W-1:0] rd_dur;

   always_comb begin
      key_code = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (keys[i]) key_code = 4'(i);
      end
   end

   assign key_rest = (keys == 16'd0);
   assign tick     = (presc_reg == PW'(TICK_DIV - 1));
   // dur never exceeds DUR_MAX-1 while held, so the tick landing on this edge always fits
   assign dur_eff  = dur_reg + DUR_W'(tick);
   assign rd_rest  = rd_data_reg[SW-1];
   assign rd_code  = rd_data_reg[DUR_W+3:DUR_W];
   assign rd_dur   = rd_data_reg[DUR_W-1:0];

   always_comb begin
      state_next      = state_reg;
      presc_next      = tick ? '0 : presc_reg + PW'(1);
      dur_next        = dur_reg;
      idx_next        = idx_reg;
      seg_active_next = seg_active_reg;
      seg_rest_next   = seg_rest_reg;
      seg_code_next   = seg_code_reg;
      hex_next        = hex_reg;
      note_on_next    = note_on_reg;
      length_next     = length_reg;
      full_next       = full_reg;
      load_pend_next  = load_pend_reg;
      rd_addr         = idx_reg + AW'(1);
      wr_en           = 1'b0;
      wr_data         = {seg_rest_reg, seg_code_reg, dur_eff};
      seg_changed     = (key_rest != seg_rest_reg) || (key_code != seg_code_reg);
      do_write        = 1'b0;

      case (state_reg)
         IDLE, REC: begin
            note_on_next = ~key_rest;
            if (!key_rest) hex_next = key_code;
            if (state_reg == IDLE) begin
               if (stop_p) begin
                  state_next = IDLE;
               end else if (rec_p) begin
                  state_next      = REC;
                  length_next     = '0;
                  full_next       = 1'b0;
                  seg_active_next = 1'b0;
                  presc_next      = '0;
               end else if (play_p && (length_reg != '0)) begin
                  state_next     = PLAY;
                  idx_next       = '0;
                  load_pend_next = 1'b1;
                  rd_addr        = '0;
                  presc_next     = '0;
               end
            end else begin
               if (stop_p) begin
                  do_write        = seg_active_reg && (dur_eff != '0);
                  seg_active_next = 1'b0;
                  state_next      = IDLE;
                  presc_next      = '0;
               end else if (!seg_active_reg) begin
                  if (!key_rest) begin
                     seg_active_next = 1'b1;
                     seg_rest_next   = 1'b0;
                     seg_code_next   = key_code;
                     dur_next        = '0;
                     presc_next      = '0;
                  end
               end else if (seg_changed) begin
                  do_write      = (dur_eff != '0);
                  seg_rest_next = key_rest;
                  seg_code_next = key_code;
                  dur_next      = '0;
                  presc_next    = '0;
               end else if (dur_eff == DUR_MAX) begin
                  do_write   = 1'b1;
                  dur_next   = '0;
                  presc_next = '0;
               end else begin
                  dur_next = dur_eff;
               end

               if (do_write) begin
                  wr_en       = 1'b1;
                  length_next = length_reg + LW'(1);
                  if (length_reg == LW'(DEPTH - 1)) begin
                     full_next       = 1'b1;
                     state_next      = IDLE;
                     seg_active_next = 1'b0;
                     presc_next      = '0;
                  end
               end
            end
         end

         PLAY: begin
            // rd_data_reg always holds the entry after idx, so segments change with no gap
            if (stop_p) begin
               state_next   = IDLE;
               note_on_next = 1'b0;
               presc_next   = '0;
            end else if (load_pend_reg) begin
               load_pend_next = 1'b0;
               hex_next       = rd_code;
               note_on_next   = ~rd_rest;
               dur_next       = rd_dur;
               presc_next     = '0;
            end else if (tick) begin
               if (dur_reg == DUR_W'(1)) begin
                  if (LW'(idx_reg) + LW'(1) == length_reg) begin
                     state_next   = IDLE;
                     note_on_next = 1'b0;
                     presc_next   = '0;
                  end else begin
                     idx_next     = idx_reg + AW'(1);
                     rd_addr      = idx_reg + AW'(2);
                     hex_next     = rd_code;
                     note_on_next = ~rd_rest;
                     dur_next     = rd_dur;
                     presc_next   = '0;
                  end
               end else begin
                  dur_next = dur_reg - DUR_W'(1);
               end
            end
         end

         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         presc_reg      <= '0;
         dur_reg        <= '0;
         idx_reg        <= '0;
         seg_active_reg <= 1'b0;
         seg_rest_reg   <= 1'b0;
         seg_code_reg   <= 4'd0;
         hex_reg        <= 4'd0;
         note_on_reg    <= 1'b0;
         length_reg     <= '0;
         full_reg       <= 1'b0;
         load_pend_reg  <= 1'b0;
      end else begin
         state_reg      <= state_next;
         presc_reg      <= presc_next;
         dur_reg        <= dur_next;
         idx_reg        <= idx_next;
         seg_active_reg <= seg_active_next;
         seg_rest_reg   <= seg_rest_next;
         seg_code_reg   <= seg_code_next;
         hex_reg        <= hex_next;
         note_on_reg    <= note_on_next;
         length_reg     <= length_next;
         full_reg       <= full_next;
         load_pend_reg  <= load_pend_next;
      end
   end

   // Segment store: contents are never reset, length guards every read
   always_ff @(posedge clk) begin
      if (wr_en) mem[length_reg[AW-1:0]] <= wr_data;
      rd_data_reg <= mem[rd_addr];
   end

   assign hex       = hex_reg;
   assign note_on   = note_on_reg;
   assign recording = (state_reg == REC);
   assign playing   = (state_reg == PLAY);
   assign full      = full_reg;
   assign length    = length_reg;

endmodule

// File: tb/tb_melody_sequencer.sv
// Randomized and directed bench for melody_sequencer: a per-cycle reference model feeds an
// expected-output queue that an independent monitor drains and compares.
module tb_melody_sequencer;

   localparam int DEPTH    = 4;
   localparam int DUR_W    = 3;
   localparam int TICK_DIV = 4;
   localparam int LW       = $clog2(DEPTH + 1);
   localparam int MAXD     = (1 << DUR_W) - 1;
   localparam int M_IDLE   = 0;
   localparam int M_REC    = 1;
   localparam int M_PLAY   = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [15:0]   keys = 16'd0;
   logic          rec_p = 1'b0, play_p = 1'b0, stop_p = 1'b0;
   logic [3:0]    hex;
   logic          note_on, recording, playing, full;
   logic [LW-1:0] length;

   always #5 clk = ~clk;

   melody_sequencer #(.DEPTH(DEPTH), .DUR_W(DUR_W), .TICK_DIV(TICK_DIV)) dut (
      .clk(clk), .rst_n(rst_n), .keys(keys), .rec_p(rec_p), .play_p(play_p), .stop_p(stop_p),
      .hex(hex), .note_on(note_on), .recording(recording), .playing(playing),
      .full(full), .length(length)
   );

   typedef struct {bit rest; int code; int dur;} seg_t;
   typedef struct {int hex; bit hex_chk; bit note_on; bit recording; bit playing; bit full; int length;} exp_t;

   exp_t exp_q[$];
   seg_t segs[$];
   int   tl_note[$];
   int   tl_hex[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state: a melody is a list of segments, playback an unrolled per-cycle timeline
   int   m_mode;
   int   m_hex;
   bit   m_hex_known;
   bit   m_note;
   bit   m_full;
   bit   seg_open;
   bit   cur_rest;
   int   cur_code;
   int   run;
   int   play_j;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
      end
   endtask

   function automatic int low_code(input logic [15:0] k);
      for (int i = 0; i < 16; i++) if (k[i]) return i;
      return 0;
   endfunction

   function automatic void model_reset();
      m_mode = M_IDLE; m_hex = 0; m_hex_known = 1; m_note = 0; m_full = 0;
      seg_open = 0; cur_rest = 0; cur_code = 0; run = 0; play_j = 0;
      segs.delete(); tl_note.delete(); tl_hex.delete(); exp_q.delete();
   endfunction

   function automatic void rec_write(input bit r, input int c, input int d);
      seg_t s;
      s.rest = r; s.code = c; s.dur = d;
      segs.push_back(s);
      if (segs.size() == DEPTH) begin
         m_full = 1; m_mode = M_IDLE; seg_open = 0;
      end
   endfunction

   task automatic step(input logic [15:0] k, input bit r, input bit p, input bit s);
      exp_t e;
      int   prev;
      bit   nrest;
      int   ncode;
      bit   changed;
      @(negedge clk);
      keys = k; rec_p = r; play_p = p; stop_p = s;
      prev  = m_mode;
      nrest = (k == 16'd0);
      ncode = low_code(k);
      if (prev != M_PLAY) begin
         m_note = !nrest;
         if (!nrest) begin m_hex = ncode; m_hex_known = 1; end
      end
      case (prev)
         M_IDLE: begin
            if (s) begin
               m_mode = M_IDLE;
            end else if (r) begin
               m_mode = M_REC; segs.delete(); m_full = 0; seg_open = 0;
            end else if (p && segs.size() > 0) begin
               m_mode = M_PLAY; play_j = 0;
               tl_note.delete(); tl_hex.delete();
               foreach (segs[i])
                  for (int c = 0; c < segs[i].dur * TICK_DIV; c++) begin
                     tl_note.push_back(segs[i].rest ? 0 : 1);
                     tl_hex.push_back(segs[i].code);
                  end
            end
         end
         M_REC: begin
            if (seg_open) run++;
            changed = seg_open && ((nrest != cur_rest) || (!nrest && ncode != cur_code));
            if (s) begin
               if (seg_open && run / TICK_DIV > 0) rec_write(cur_rest, cur_code, run / TICK_DIV);
               m_mode = M_IDLE; seg_open = 0;
            end else if (!seg_open) begin
               if (!nrest) begin seg_open = 1; cur_rest = 0; cur_code = ncode; run = 0; end
            end else if (changed) begin
               if (run / TICK_DIV > 0) rec_write(cur_rest, cur_code, run / TICK_DIV);
               cur_rest = nrest; cur_code = nrest ? 0 : ncode; run = 0;
            end else if (run / TICK_DIV == MAXD) begin
               rec_write(cur_rest, cur_code, MAXD);
               run = 0;
            end
         end
         default: begin
            if (s) begin
               m_mode = M_IDLE; m_note = 0;
            end else begin
               play_j++;
               if (play_j - 1 < tl_note.size()) begin
                  m_note = tl_note[play_j-1] != 0;
                  m_hex = tl_hex[play_j-1];
                  m_hex_known = m_note;
               end else begin
                  m_mode = M_IDLE; m_note = 0;
               end
            end
         end
      endcase
      e.hex = m_hex; e.hex_chk = m_hex_known; e.note_on = m_note;
      e.recording = (m_mode == M_REC); e.playing = (m_mode == M_PLAY);
      e.full = m_full; e.length = segs.size();
      exp_q.push_back(e);
   endtask

   task automatic phase(input string name);
      $display("txn %-10s t=%0t length=%0d full=%0d", name, $time, length, full);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.hex_chk) chk("hex", int'(hex), e.hex);
            chk("note_on", int'(note_on), int'(e.note_on));
            chk("recording", int'(recording), int'(e.recording));
            chk("playing", int'(playing), int'(e.playing));
            chk("full", int'(full), int'(e.full));
            chk("length", int'(length), e.length);
         end
      end
   end

   initial begin : stim
      logic [15:0] rk;
      int hold;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hex", int'(hex), 0);
      chk("rst_note_on", int'(note_on), 0);
      chk("rst_length", int'(length), 0);
      chk("rst_state", int'({recording, playing}), 0);
      @(negedge clk);
      rst_n = 1'b1;

      phase("live");
      step(16'h0008, 0, 0, 0); step(16'h0008, 0, 0, 0);
      step(16'h0000, 0, 0, 0); step(16'h0000, 0, 0, 0);

      phase("record");
      step(16'h0000, 1, 0, 0);
      repeat (12) step(16'h0004, 0, 0, 0);
      repeat (8)  step(16'h0000, 0, 0, 0);
      repeat (4)  step(16'h0020, 0, 0, 0);
      step(16'h0000, 0, 0, 1);
      phase("play");
      step(16'h0000, 0, 1, 0);
      repeat (30) step(16'h0000, 0, 0, 0);

      phase("priority");
      step(16'h0000, 0, 1, 1);
      step(16'h0000, 0, 0, 0);
      step(16'h0000, 1, 1, 0);
      repeat (3) step(16'h0000, 0, 0, 0);
      step(16'h0000, 0, 0, 1);
      step(16'h0000, 0, 1, 0);
      step(16'h0000, 0, 0, 0);

      phase("glitch");
      step(16'h0000, 1, 0, 0);
      repeat (8) step(16'h0001, 0, 0, 0);
      repeat (2) step(16'h0010, 0, 0, 0);
      repeat (8) step(16'h0001, 0, 0, 0);
      step(16'h0000, 0, 0, 1);
      step(16'h0000, 0, 1, 0);
      repeat (20) step(16'h0000, 0, 0, 0);

      phase("saturate");
      step(16'h0000, 1, 0, 0);
      repeat (125) step(16'h0002, 0, 0, 0);
      step(16'h0000, 0, 1, 0);
      repeat (115) step(16'h0000, 0, 0, 0);

      phase("random");
      hold = 0;
      rk = 16'd0;
      for (int n = 0; n < 2500; n++) begin
         if (hold == 0) begin
            if ($urandom % 3 == 0) rk = 16'd0;
            else rk = (16'd1 << ($urandom % 16)) | (($urandom % 4 == 0) ? 16'($urandom) : 16'd0);
            hold = $urandom_range(1, 14);
         end
         hold--;
         step(rk, ($urandom % 40) == 0, ($urandom % 30) == 0, ($urandom % 60) == 0);
      end

      phase("async_rst");
      step(16'h0000, 0, 0, 1);
      step(16'h0000, 0, 0, 1);
      step(16'h0000, 1, 0, 0);
      repeat (8) step(16'h0100, 0, 0, 0);
      repeat (8) step(16'h0400, 0, 0, 0);
      step(16'h0000, 0, 0, 1);
      step(16'h0000, 0, 1, 0);
      repeat (10) step(16'h0000, 0, 0, 0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_hex", int'(hex), 0);
      chk("arst_note_on", int'(note_on), 0);
      chk("arst_playing", int'(playing), 0);
      chk("arst_recording", int'(recording), 0);
      chk("arst_length", int'(length), 0);
      chk("arst_full", int'(full), 0);
      repeat (2) @(negedge clk);
      model_reset();
      rst_n = 1'b1;
      step(16'h0000, 0, 1, 0);
      repeat (3) step(16'h0000, 0, 0, 0);
      @(posedge clk);
      #3;
      chk("queue_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
